// File: rtl/hazard_if.sv
// Hazard interface between the RV32I datapath and its pipeline control block.
// The datapath (master) exports register indices and control bits and receives stall/flush/forward selects.
interface hazard_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           Rs1D;
    logic [4:0]           Rs2D;
    logic [4:0]           Rs1E;
    logic [4:0]           Rs2E;
    logic [4:0]           RdE;
    logic [4:0]           RdM;
    logic [4:0]           RdW;
    logic                 ResultSrcE_zero;
    logic                 RegWriteM;
    logic                 RegWriteW;
    logic                 PCSrcE;
    logic                 halt_req;
    logic                 cnt_clr;

    logic                 StallF;
    logic                 StallD;
    logic                 FlushD;
    logic                 FlushE;
    logic [1:0]           ForwardAE;
    logic [1:0]           ForwardBE;
    logic                 halt_ack;
    logic [CNT_WIDTH-1:0] lu_stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;
    logic [CNT_WIDTH-1:0] halt_cyc_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, halt_req, cnt_clr,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
        input  halt_ack, lu_stall_cnt, flush_cnt, halt_cyc_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, halt_req, cnt_clr,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
        output halt_ack, lu_stall_cnt, flush_cnt, halt_cyc_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline control for the 5-stage RV32I core: forwarding, load-use stall, branch flush,
// a debug-halt controller that drains the back end, and saturating event counters.
module hazard_unit #(
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hz
);
    localparam int DW = (DRAIN_CYCLES + 1 > 2) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] drain_next;

    logic                 lw_stall;
    logic                 run_mode;
    logic                 stall_f;
    logic                 stall_d;
    logic                 flush_d;
    logic                 flush_e;
    logic [CNT_WIDTH-1:0] lu_stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;
    logic [CNT_WIDTH-1:0] halt_cyc_cnt;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (reg_write_m && (rd_m == rs) && (rs != 5'd0)) begin
            sel = 2'b10;
        end else if (reg_write_w && (rd_w == rs) && (rs != 5'd0)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

    // No x0 exclusion here: the datapath's load-use check compares raw indices.
    assign lw_stall = hz.ResultSrcE_zero && ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
    assign run_mode = reset || (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        unique case (state)
            RUN: begin
                if (hz.halt_req) begin
                    state_next = DRAIN;
                    drain_next = '0;
                end
            end
            DRAIN: begin
                if (!hz.halt_req) begin
                    state_next = RUN;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_next = HALTED;
                end else begin
                    drain_next = drain_cnt + DW'(1);
                end
            end
            HALTED: begin
                if (!hz.halt_req) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                drain_next = '0;
            end
        endcase
    end

    // While draining or halted, ID is held and EX receives bubbles, but a redirect still wins.
    always_comb begin
        stall_f = lw_stall;
        stall_d = lw_stall;
        flush_d = hz.PCSrcE;
        flush_e = lw_stall || hz.PCSrcE;
        if (!run_mode) begin
            stall_f = !hz.PCSrcE;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hz.StallF   = stall_f;
    assign hz.StallD   = stall_d;
    assign hz.FlushD   = flush_d;
    assign hz.FlushE   = flush_e;
    assign hz.halt_ack = (state == HALTED);

    always_ff @(posedge clk) begin
        if (reset || hz.cnt_clr) begin
            lu_stall_cnt <= '0;
            flush_cnt    <= '0;
            halt_cyc_cnt <= '0;
        end else begin
            if ((state == RUN) && lw_stall) begin
                lu_stall_cnt <= sat_inc(lu_stall_cnt);
            end
            if (hz.PCSrcE) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
            if (state == HALTED) begin
                halt_cyc_cnt <= sat_inc(halt_cyc_cnt);
            end
        end
    end

    assign hz.lu_stall_cnt = lu_stall_cnt;
    assign hz.flush_cnt    = flush_cnt;
    assign hz.halt_cyc_cnt = halt_cyc_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vectors, a cycle-level reference model, and literal spot checks.
// Two instances share stimulus: default 32-bit counters and 4-bit counters for saturation.
module tb_hazard_unit;
    localparam int D = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   started;

    hazard_if #(.CNT_WIDTH(32)) bus ();
    hazard_if #(.CNT_WIDTH(4))  bus4 ();

    hazard_unit #(.CNT_WIDTH(32), .DRAIN_CYCLES(D)) dut  (.clk(clk), .reset(reset), .hz(bus));
    hazard_unit #(.CNT_WIDTH(4),  .DRAIN_CYCLES(D)) dut4 (.clk(clk), .reset(reset), .hz(bus4));

    assign bus4.Rs1D            = bus.Rs1D;
    assign bus4.Rs2D            = bus.Rs2D;
    assign bus4.Rs1E            = bus.Rs1E;
    assign bus4.Rs2E            = bus.Rs2E;
    assign bus4.RdE             = bus.RdE;
    assign bus4.RdM             = bus.RdM;
    assign bus4.RdW             = bus.RdW;
    assign bus4.ResultSrcE_zero = bus.ResultSrcE_zero;
    assign bus4.RegWriteM       = bus.RegWriteM;
    assign bus4.RegWriteW       = bus.RegWriteW;
    assign bus4.PCSrcE          = bus.PCSrcE;
    assign bus4.halt_req        = bus.halt_req;
    assign bus4.cnt_clr         = bus.cnt_clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: h counts consecutive cycles halt_req has been sampled high
    // (capped), so h==0 is RUN, 1..D is DRAIN and anything above D is HALTED.
    int          h;
    logic [63:0] m_lu, m_fl, m_hc, m4_lu, m4_fl, m4_hc;

    function automatic logic [63:0] sat(input logic [63:0] v, input logic [63:0] max);
        return (v < max) ? v + 64'd1 : v;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (bus.RegWriteM && bus.RdM == rs && rs != 0) return 2'b10;
        if (bus.RegWriteW && bus.RdW == rs && rs != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_lw();
        return bus.ResultSrcE_zero && (bus.Rs1D == bus.RdE || bus.Rs2D == bus.RdE);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            h = 0;
            m_lu = 0; m_fl = 0; m_hc = 0;
            m4_lu = 0; m4_fl = 0; m4_hc = 0;
        end else begin
            if (bus.cnt_clr) begin
                m_lu = 0; m_fl = 0; m_hc = 0;
                m4_lu = 0; m4_fl = 0; m4_hc = 0;
            end else begin
                if (h == 0 && exp_lw()) begin
                    m_lu = sat(m_lu, 64'hFFFF_FFFF);
                    m4_lu = sat(m4_lu, 64'd15);
                end
                if (bus.PCSrcE) begin
                    m_fl = sat(m_fl, 64'hFFFF_FFFF);
                    m4_fl = sat(m4_fl, 64'd15);
                end
                if (h > D) begin
                    m_hc = sat(m_hc, 64'hFFFF_FFFF);
                    m4_hc = sat(m4_hc, 64'd15);
                end
            end
            h = bus.halt_req ? ((h < D + 1) ? h + 1 : h) : 0;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            automatic bit run = reset || (h == 0);
            automatic bit lw  = exp_lw();
            chk("ForwardAE", bus.ForwardAE, exp_fwd(bus.Rs1E));
            chk("ForwardBE", bus.ForwardBE, exp_fwd(bus.Rs2E));
            chk("StallF", bus.StallF, run ? lw : !bus.PCSrcE);
            chk("StallD", bus.StallD, run ? lw : 1'b1);
            chk("FlushD", bus.FlushD, bus.PCSrcE);
            chk("FlushE", bus.FlushE, run ? (lw || bus.PCSrcE) : 1'b1);
            chk("halt_ack", bus.halt_ack, (h > D));
            chk("lu_stall_cnt", bus.lu_stall_cnt, m_lu);
            chk("flush_cnt", bus.flush_cnt, m_fl);
            chk("halt_cyc_cnt", bus.halt_cyc_cnt, m_hc);
            chk("w4 StallD", bus4.StallD, run ? lw : 1'b1);
            chk("w4 halt_ack", bus4.halt_ack, (h > D));
            chk("w4 lu_stall_cnt", bus4.lu_stall_cnt, m4_lu);
            chk("w4 flush_cnt", bus4.flush_cnt, m4_fl);
            chk("w4 halt_cyc_cnt", bus4.halt_cyc_cnt, m4_hc);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        started = 1'b0;
        h = 0;
        m_lu = 0; m_fl = 0; m_hc = 0;
        m4_lu = 0; m4_fl = 0; m4_hc = 0;
        reset = 1'b1;
        bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0;
        bus.RdE = 0; bus.RdM = 0; bus.RdW = 0;
        bus.ResultSrcE_zero = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
        bus.PCSrcE = 0; bus.halt_req = 0; bus.cnt_clr = 0;

        repeat (2) tick();
        #1;
        chk("reset halt_ack", bus.halt_ack, 0);
        chk("reset lu_stall_cnt", bus.lu_stall_cnt, 0);
        chk("reset flush_cnt", bus.flush_cnt, 0);
        chk("reset halt_cyc_cnt", bus.halt_cyc_cnt, 0);
        reset = 1'b0;

        // Forwarding on operand A: MEM beats WB, x0 never forwards
        tick();
        bus.Rs1E = 5; bus.RdM = 5; bus.RegWriteM = 1; bus.RdW = 5; bus.RegWriteW = 1;
        #1 chk("fwdA mem", bus.ForwardAE, 2'b10);
        bus.RegWriteM = 0;
        #1 chk("fwdA wb", bus.ForwardAE, 2'b01);
        bus.Rs1E = 0; bus.RdM = 0; bus.RdW = 0; bus.RegWriteM = 1;
        #1 chk("fwdA x0", bus.ForwardAE, 2'b00);

        // Forwarding on operand B
        tick();
        bus.Rs2E = 9; bus.RdM = 9; bus.RdW = 9; bus.RegWriteM = 1; bus.RegWriteW = 1;
        #1 chk("fwdB mem", bus.ForwardBE, 2'b10);
        bus.RegWriteM = 0;
        #1 chk("fwdB wb", bus.ForwardBE, 2'b01);
        bus.Rs2E = 0; bus.RdM = 0; bus.RdW = 0; bus.RegWriteM = 1;
        #1 chk("fwdB x0", bus.ForwardBE, 2'b00);

        // Load-use stall
        tick();
        bus.RegWriteM = 0; bus.RegWriteW = 0;
        bus.ResultSrcE_zero = 1; bus.RdE = 7; bus.Rs2D = 7;
        #1;
        chk("lw StallF", bus.StallF, 1);
        chk("lw StallD", bus.StallD, 1);
        chk("lw FlushE", bus.FlushE, 1);
        chk("lw FlushD", bus.FlushD, 0);
        tick();
        bus.Rs2D = 8;
        #1;
        chk("lw cnt", bus.lu_stall_cnt, 1);
        chk("nolw StallF", bus.StallF, 0);
        chk("nolw StallD", bus.StallD, 0);
        chk("nolw FlushE", bus.FlushE, 0);
        chk("nolw FlushD", bus.FlushD, 0);

        // Branch redirect in RUN
        tick();
        bus.ResultSrcE_zero = 0;
        bus.PCSrcE = 1;
        #1;
        chk("br FlushD", bus.FlushD, 1);
        chk("br FlushE", bus.FlushE, 1);
        chk("br StallF", bus.StallF, 0);
        tick();
        bus.PCSrcE = 0;
        #1 chk("br flush_cnt", bus.flush_cnt, 1);

        // Full halt: 3 DRAIN cycles, then HALTED for 5 cycles, then release
        tick();
        bus.halt_req = 1;
        #1 chk("halt N ack", bus.halt_ack, 0);
        for (int i = 0; i < D; i++) begin
            tick();
            chk("drain StallD", bus.StallD, 1);
            chk("drain FlushE", bus.FlushE, 1);
            chk("drain ack", bus.halt_ack, 0);
        end
        tick();
        chk("halted ack", bus.halt_ack, 1);
        repeat (4) tick();
        bus.halt_req = 0;
        tick();
        chk("resume halt_cyc_cnt", bus.halt_cyc_cnt, 5);
        chk("resume ack", bus.halt_ack, 0);
        chk("resume StallD", bus.StallD, 0);

        // Two-cycle halt pulse aborts the drain
        tick();
        bus.halt_req = 1;
        tick();
        chk("pulse d1 ack", bus.halt_ack, 0);
        chk("pulse d1 StallD", bus.StallD, 1);
        tick();
        bus.halt_req = 0;
        #1 chk("pulse d2 ack", bus.halt_ack, 0);
        tick();
        chk("pulse run StallD", bus.StallD, 0);
        chk("pulse run ack", bus.halt_ack, 0);

        // Redirect in the first DRAIN cycle
        bus.halt_req = 1;
        tick();
        bus.PCSrcE = 1;
        #1;
        chk("drain br StallF", bus.StallF, 0);
        chk("drain br FlushD", bus.FlushD, 1);
        chk("drain br StallD", bus.StallD, 1);
        chk("drain br FlushE", bus.FlushE, 1);
        tick();
        bus.PCSrcE = 0; bus.halt_req = 0;
        #1 chk("drain br flush_cnt", bus.flush_cnt, 2);
        tick();

        // Sustained load-use stall: 4-bit counter saturates
        bus.ResultSrcE_zero = 1; bus.RdE = 7; bus.Rs1D = 7; bus.Rs2D = 0;
        repeat (20) tick();
        chk("sat w4 lu", bus4.lu_stall_cnt, 15);
        chk("sat w32 lu", bus.lu_stall_cnt, 21);
        bus.cnt_clr = 1;
        tick();
        bus.cnt_clr = 0;
        #1;
        chk("clr w4 lu", bus4.lu_stall_cnt, 0);
        chk("clr w32 lu", bus.lu_stall_cnt, 0);
        chk("clr flush_cnt", bus.flush_cnt, 0);
        bus.ResultSrcE_zero = 0;

        // Reset while HALTED
        bus.halt_req = 1;
        repeat (D + 1) tick();
        chk("pre-reset ack", bus.halt_ack, 1);
        tick();
        reset = 1;
        #1;
        chk("reset-high StallD", bus.StallD, 0);
        chk("reset-high FlushE", bus.FlushE, 0);
        chk("reset-high ack", bus.halt_ack, 1);
        tick();
        chk("post-reset ack", bus.halt_ack, 0);
        chk("post-reset halt_cyc_cnt", bus.halt_cyc_cnt, 0);
        chk("post-reset flush_cnt", bus.flush_cnt, 0);
        bus.halt_req = 0;
        reset = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
